// File: rtl/phy_tx_ser.sv
// Two-lane byte-striped serializer fed by a 2-entry word FIFO; one word per 16-cycle frame, idle 0xBC otherwise.
// Latency 16-j cycles from a push at cnt==j (j<15), +16 if j==15; ready_input drops while two words are pending.

module phy_tx_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_vld,
  input  logic [W-1:0]               wr_dat,
  input  logic                       rd_vld,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The caller guarantees no write when full and no read when empty.
  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_vld) wr_ptr <= next_ptr(wr_ptr);
      if (rd_vld) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_vld, rd_vld})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_dat = mem[rd_ptr];
endmodule

module phy_tx_ser #(
  parameter int         FRAME_LEN = 16,
  parameter logic [7:0] IDLE_BYTE = 8'hBC
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_input,
  input  logic        valid_input,
  output logic        ready_input,
  output logic        par_ser_1,
  output logic        par_ser_2,
  output logic        tx_active,
  output logic        frame_start
);
  localparam int             CW   = $clog2(FRAME_LEN);
  localparam logic [CW-1:0]  LAST = CW'(FRAME_LEN - 1);
  localparam logic [15:0]    IDLE_PAIR = {IDLE_BYTE, IDLE_BYTE};

  typedef struct packed {
    logic [7:0] b3;
    logic [7:0] b2;
    logic [7:0] b1;
    logic [7:0] b0;
  } word_t;

  logic [CW-1:0] cnt;
  logic [15:0]   sr1;
  logic [15:0]   sr2;
  logic [1:0]    fifo_cnt;
  word_t         head;
  logic          load;
  logic          wr_vld;
  logic          rd_vld;

  assign ready_input = (fifo_cnt != 2'd2);
  assign wr_vld      = valid_input && ready_input;
  assign load        = (cnt == LAST);
  assign rd_vld      = load && (fifo_cnt != 2'd0);

  phy_tx_fifo #(.W(32), .DEPTH(2)) u_fifo (
    .clk    (clk_32f),
    .reset  (reset),
    .wr_vld (wr_vld),
    .wr_dat (data_input),
    .rd_vld (rd_vld),
    .rd_dat (head),
    .count  (fifo_cnt)
  );

  always_ff @(posedge clk_32f) begin
    if (reset) cnt <= '0;
    else       cnt <= load ? '0 : cnt + 1'b1;
  end

  // Lane 1 takes the odd bytes (31:24, 15:8), lane 2 the even ones, so each lane sends two bytes per frame.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr1       <= IDLE_PAIR;
      sr2       <= IDLE_PAIR;
      tx_active <= 1'b0;
    end else if (load) begin
      sr1       <= rd_vld ? {head.b3, head.b1} : IDLE_PAIR;
      sr2       <= rd_vld ? {head.b2, head.b0} : IDLE_PAIR;
      tx_active <= rd_vld;
    end else begin
      sr1 <= {sr1[14:0], 1'b0};
      sr2 <= {sr2[14:0], 1'b0};
    end
  end

  assign par_ser_1   = sr1[15];
  assign par_ser_2   = sr2[15];
  assign frame_start = (cnt == '0);
endmodule

// File: tb/tb_phy_tx_ser.sv
// Directed bench for phy_tx_ser: frame-aligned lane capture against hand-computed byte pairs.
module tb_phy_tx_ser;
  logic        clk_32f = 1'b0;
  logic        reset;
  logic [31:0] data_input;
  logic        valid_input;
  logic        ready_input;
  logic        par_ser_1;
  logic        par_ser_2;
  logic        tx_active;
  logic        frame_start;

  int vectors     = 0;
  int miscompares = 0;
  int k           = 0;   // expected cnt at the current sample point
  int mc          = 0;   // expected FIFO occupancy
  logic bp_on     = 1'b0;
  int bp_idx      = 0;

  phy_tx_ser dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_input  (data_input),
    .valid_input (valid_input),
    .ready_input (ready_input),
    .par_ser_1   (par_ser_1),
    .par_ser_2   (par_ser_2),
    .tx_active   (tx_active),
    .frame_start (frame_start)
  );

  always #5 clk_32f = ~clk_32f;

  initial begin
    #200000;
    $error("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled at the falling edge, inputs change there too.
  task automatic step();
    logic rst_now;
    logic pushed;
    logic popped;
    rst_now = reset;
    if (!rst_now) begin
      check("ready", {31'b0, ready_input}, {31'b0, (mc != 2)});
      check("frame_start", {31'b0, frame_start}, {31'b0, (k == 0)});
    end
    pushed = valid_input && (mc != 2);
    popped = (k == 15) && (mc != 0);
    @(negedge clk_32f);
    if (rst_now) begin
      k  = 0;
      mc = 0;
    end else begin
      k  = (k + 1) % 16;
      mc = mc + int'(pushed) - int'(popped);
    end
    if (bp_on) begin
      if (pushed) bp_idx++;
      valid_input = (bp_idx < 5);
      data_input  = 32'(bp_idx + 1);
    end
  endtask

  task automatic wait_k(input int j);
    while (k != j) step();
  endtask

  task automatic push(input logic [31:0] w);
    data_input  = w;
    valid_input = 1'b1;
    step();
    valid_input = 1'b0;
  endtask

  task automatic frame(input string tag, input logic [15:0] e1, input logic [15:0] e2, input logic eact);
    logic [15:0] l1;
    logic [15:0] l2;
    l1 = '0;
    l2 = '0;
    for (int i = 0; i < 16; i++) begin
      l1 = {l1[14:0], par_ser_1};
      l2 = {l2[14:0], par_ser_2};
      check({tag, "_act"}, {31'b0, tx_active}, {31'b0, eact});
      step();
    end
    check({tag, "_lane1"}, {16'b0, l1}, {16'b0, e1});
    check({tag, "_lane2"}, {16'b0, l2}, {16'b0, e2});
  endtask

  task automatic reset_state(input string tag);
    check({tag, "_ser1"},  {31'b0, par_ser_1},   32'd1);
    check({tag, "_ser2"},  {31'b0, par_ser_2},   32'd1);
    check({tag, "_ready"}, {31'b0, ready_input}, 32'd1);
    check({tag, "_act"},   {31'b0, tx_active},   32'd0);
    check({tag, "_fs"},    {31'b0, frame_start}, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    valid_input = 1'b0;
    data_input  = '0;

    // Power-on reset for 3 cycles, then one all-idle frame.
    repeat (3) step();
    reset_state("rst0");
    reset = 1'b0;
    frame("rst_idle", 16'hBCBC, 16'hBCBC, 1'b0);

    // Single word pushed mid-frame shows up at the next frame boundary.
    wait_k(3);
    push(32'hA1B2C3D4);
    wait_k(0);
    frame("single", 16'hA1C3, 16'hB2D4, 1'b1);
    frame("single_after", 16'hBCBC, 16'hBCBC, 1'b0);

    // Push into an empty FIFO on the load cycle: one idle frame first.
    wait_k(15);
    push(32'hDEADBEEF);
    frame("bnd_idle", 16'hBCBC, 16'hBCBC, 1'b0);
    frame("bnd_data", 16'hDEBE, 16'hADEF, 1'b1);

    // Occupancy 1 with push and pop on the same edge.
    wait_k(5);
    push(32'h11223344);
    wait_k(15);
    push(32'h55667788);
    check("simul_ready", {31'b0, ready_input}, 32'd1);
    frame("simul_a", 16'h1133, 16'h2244, 1'b1);
    frame("simul_b", 16'h5577, 16'h6688, 1'b1);
    frame("simul_idle", 16'hBCBC, 16'hBCBC, 1'b0);

    // Back-pressure: valid held high across five words.
    bp_on       = 1'b1;
    bp_idx      = 0;
    data_input  = 32'd1;
    valid_input = 1'b1;
    frame("bp_idle", 16'hBCBC, 16'hBCBC, 1'b0);
    for (int i = 0; i < 5; i++) begin
      frame($sformatf("bp_w%0d", i), 16'h0000, 16'(i + 1), 1'b1);
    end
    bp_on       = 1'b0;
    valid_input = 1'b0;
    check("bp_count", bp_idx, 32'd5);
    frame("bp_tail", 16'hBCBC, 16'hBCBC, 1'b0);

    // Reset mid-frame with two words queued: both discarded.
    wait_k(2);
    push(32'hCAFE0001);
    push(32'hCAFE0002);
    wait_k(9);
    reset = 1'b1;
    repeat (3) step();
    reset_state("rst1");
    reset = 1'b0;
    frame("rst1_idle0", 16'hBCBC, 16'hBCBC, 1'b0);
    frame("rst1_idle1", 16'hBCBC, 16'hBCBC, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
